// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver: captures words on rx_done and presents
// them first-word-fall-through on a valid/ready port, with fill level and sticky overflow.
module uart_rx_fifo #(
   parameter int unsigned DBITS    = 8,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned AF_LEVEL = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_done,
   input  logic [DBITS-1:0]  rx_data,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [DBITS-1:0]  rd_data,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              overflow,
   input  logic              ovf_clr
);

   localparam int unsigned     DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W + 1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   logic [DBITS-1:0]  mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              push, pop, drop;

   // Flags decode straight from the registered count so they carry no extra latency.
   always_comb begin
      empty       = (count_q == '0);
      full        = (count_q == FULL_CNT);
      almost_full = (count_q >= AF_CNT);
      rd_valid    = !empty;
      rd_data     = mem_q[rd_ptr_q];
      count       = count_q;
      overflow    = ovf_q;
   end

   // A write into a full FIFO still lands when the head is popped in the same cycle.
   always_comb begin
      pop      = rd_valid & rd_ready;
      push     = rx_done & (!full | pop);
      drop     = rx_done & full & !pop;
      wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      ovf_d = drop | (ovf_q & !ovf_clr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && rst) begin
         mem_q[wr_ptr_q] <= rx_data;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and scoreboarded checks of uart_rx_fifo: ordering, flags, overflow, wrap and async reset.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx_done = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rd_ready = 1'b0;
   logic       ovf_clr = 1'b0;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic [4:0] count;
   logic       empty, full, almost_full, overflow;

   int unsigned chk_cnt  = 0;
   int unsigned pass_cnt = 0;

   uart_rx_fifo #(.DBITS(8), .ADDR_W(4), .AF_LEVEL(12)) dut (
      .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
      .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
      .count(count), .empty(empty), .full(full), .almost_full(almost_full),
      .overflow(overflow), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         pass_cnt++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [7:0] d);
      rx_done = 1'b1;
      rx_data = d;
      tick();
      rx_done = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [7:0] sb [$];
      logic [7:0] next_word;
      logic       m_pop, m_push, m_ovf;
      int unsigned pushed, cyc;

      // 1: reset state
      #3;
      check_eq("rst_empty", empty, 1);
      check_eq("rst_full", full, 0);
      check_eq("rst_count", count, 0);
      check_eq("rst_valid", rd_valid, 0);
      check_eq("rst_af", almost_full, 0);
      check_eq("rst_ovf", overflow, 0);
      rx_done = 1'b1; rx_data = 8'h77;
      tick();
      rx_done = 1'b0;
      check_eq("rst_ignore_push", count, 0);
      #1 rst = 1'b1;
      tick();

      // 2: two words, hold then read in order
      push_word(8'hA5);
      check_eq("t2_lat_valid", rd_valid, 1);
      check_eq("t2_lat_data", rd_data, 8'hA5);
      push_word(8'h3C);
      check_eq("t2_count", count, 2);
      tick();
      check_eq("t2_hold", rd_data, 8'hA5);
      rd_ready = 1'b1;
      check_eq("t2_rd0", rd_data, 8'hA5);
      tick();
      check_eq("t2_rd1", rd_data, 8'h3C);
      tick();
      rd_ready = 1'b0;
      check_eq("t2_empty", empty, 1);
      check_eq("t2_count0", count, 0);

      // 3: fill, almost_full threshold, drop, drain
      for (int i = 0; i < 16; i++) begin
         push_word(8'(i));
         check_eq("t3_af", almost_full, (i + 1 >= 12) ? 1 : 0);
         check_eq("t3_full", full, (i == 15) ? 1 : 0);
      end
      push_word(8'hFF);
      check_eq("t3_ovf", overflow, 1);
      check_eq("t3_count16", count, 16);
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check_eq("t3_drain", rd_data, 8'(i));
         tick();
      end
      rd_ready = 1'b0;
      check_eq("t3_empty", empty, 1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check_eq("t3_ovf_clr", overflow, 0);

      // 4: push into full with simultaneous pop
      for (int i = 0; i < 16; i++) push_word(8'(8'h10 + i));
      check_eq("t4_full", full, 1);
      rx_done = 1'b1; rx_data = 8'h55; rd_ready = 1'b1;
      tick();
      rx_done = 1'b0; rd_ready = 1'b0;
      check_eq("t4_count", count, 16);
      check_eq("t4_ovf", overflow, 0);
      rd_ready = 1'b1;
      for (int i = 1; i < 16; i++) begin
         check_eq("t4_drain", rd_data, 8'(8'h10 + i));
         tick();
      end
      check_eq("t4_16th", rd_data, 8'h55);
      tick();
      rd_ready = 1'b0;
      check_eq("t4_empty", empty, 1);

      // 5: random traffic against a queue model
      pushed = 0; cyc = 0; next_word = 8'h80; m_ovf = 1'b0;
      while ((pushed < 100 || sb.size() != 0) && cyc < 5000) begin
         rx_done  = (pushed < 100) && ($urandom_range(0, 1) == 1);
         rx_data  = next_word;
         rd_ready = ($urandom_range(0, 4) < 3);
         check_eq("t5_count", count, sb.size());
         check_eq("t5_valid", rd_valid, (sb.size() != 0) ? 1 : 0);
         if (sb.size() != 0) check_eq("t5_data", rd_data, sb[0]);
         m_pop  = (sb.size() != 0) && rd_ready;
         m_push = rx_done && (sb.size() < 16 || m_pop);
         if (rx_done && !m_push) m_ovf = 1'b1;
         if (m_pop) void'(sb.pop_front());
         if (m_push) begin
            sb.push_back(next_word);
            next_word++;
            pushed++;
         end
         tick();
         cyc++;
      end
      rx_done = 1'b0; rd_ready = 1'b0;
      check_eq("t5_done", (cyc < 5000) ? 1 : 0, 1);
      check_eq("t5_ovf", overflow, m_ovf);
      check_eq("t5_empty", empty, 1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;

      // 6: ovf_clr vs drop priority, then async reset mid-fill
      for (int i = 0; i < 16; i++) push_word(8'(8'hC0 + i));
      rx_done = 1'b1; rx_data = 8'hEE; ovf_clr = 1'b1;
      tick();
      rx_done = 1'b0; ovf_clr = 1'b0;
      check_eq("t6_drop_wins", overflow, 1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check_eq("t6_clr", overflow, 0);
      rd_ready = 1'b1;
      repeat (11) tick();
      rd_ready = 1'b0;
      check_eq("t6_count5", count, 5);
      check_eq("t6_head", rd_data, 8'hCB);
      #1 rst = 1'b0;
      #1;
      check_eq("t6_async_empty", empty, 1);
      check_eq("t6_async_count", count, 0);
      check_eq("t6_async_valid", rd_valid, 0);
      tick();
      rst = 1'b1;
      tick();
      check_eq("t6_post_rst", count, 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
